parity_arbiter: RTL and testbench
=================================

PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, giving the width of each request word.
REQ-003 The module SHALL have parameter ODD, default 0; 0 selects even parity (XOR of bits), 1 selects odd parity (inverted XOR).
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset; asynchronous and active-high.
REQ-006 Port: req_valid  input  NUM_REQ  per-requester request pending.
REQ-007 Port: req_data  input  NUM_REQ*DATA_WIDTH  request words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: req_check  input  NUM_REQ  per-requester check mode: compare the computed parity against req_exp.
REQ-009 Port: req_exp  input  NUM_REQ  per-requester expected parity bit, used only when req_check is set.
REQ-010 Port: req_ready  output  NUM_REQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-011 Port: out_valid  output  1  result register holds a valid result.
REQ-012 Port: out_ready  input  1  consumer accepts the result.
REQ-013 Port: out_id  output  clog2(NUM_REQ)  index of the requester that produced the result.
REQ-014 Port: out_parity  output  1  computed parity of the accepted word.
REQ-015 Port: out_error  output  1  high when check mode was set and out_parity != req_exp; otherwise 0.
REQ-016 Port: err_count  output  8  number of results delivered with out_error=1; saturates at 8'hFF.

Function
REQ-017 The output stage SHALL be a one-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 The output slot SHALL be free in a cycle when the stage is EMPTY, or when it is FULL and out_ready=1 in that cycle (pass-through in the same cycle).
REQ-019 When the slot is free and any req_valid bit is high, exactly one req_ready bit SHALL be asserted, combinationally; otherwise req_ready SHALL be all zero.
REQ-020 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ and wraps to find the first requester with req_valid high.
REQ-021 last_grant SHALL update to the granted index only on a transfer.
REQ-022 On a transfer in cycle N, the result SHALL appear in cycle N+1 (out_valid=1, out_id, out_parity, out_error), giving one cycle of latency.
REQ-023 out_parity SHALL be the XOR of all DATA_WIDTH bits of the granted word, inverted when ODD=1.
REQ-024 Transitions: EMPTY with transfer -> FULL; FULL with out_ready and no transfer -> EMPTY; FULL with out_ready and transfer -> FULL with the new result; FULL with !out_ready -> FULL, holding all out_* values stable.
REQ-025 err_count SHALL increment by 1 in the cycle a result with out_error=1 is consumed (out_valid & out_ready), and SHALL stay at 8'hFF once reached.
REQ-026 Sustained throughput SHALL be one result per cycle while out_ready stays high.
REQ-027 A requester that keeps req_valid high SHALL be granted within NUM_REQ transfers.
REQ-028 req_data, req_check and req_exp of non-granted requesters SHALL have no effect on any state.

Reset
REQ-029 While rst=1, regardless of clk: out_valid=0, out_id=0, out_parity=0, out_error=0, err_count=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), req_ready all zero.
REQ-030 If reset asserts mid-operation, a pending result SHALL be discarded without being counted; operation resumes on the first rising edge after rst deasserts.

Verification
REQ-031 After reset, req_valid=4'b1111 with out_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles; out_id follows one cycle later.
REQ-032 Requester 2 sends data 8'hA5 with ODD=0 -> out_parity=0; data 8'h07 -> out_parity=1; with ODD=1 both results invert.
REQ-033 out_ready=0 for 3 cycles with result FULL and req_valid=4'b0011 -> req_ready=0 throughout and out_* held stable; when out_ready rises, the next grant occurs in that same cycle.
REQ-034 Check mode: requester 1 sends data 8'h01 with req_exp=0 -> out_error=1 and err_count increments to 1 on consumption; 300 such errors -> err_count=8'hFF.
REQ-035 Assert rst while FULL with out_error=1 -> out_valid drops immediately (asynchronously), err_count=0, and the first grant after release goes to requester 0.
REQ-036 Only requester 3 valid, continuously -> granted every cycle, and last_grant=3 does not block it.

Source files
------------

// File: rtl/parity_arbiter.sv
// parity_arbiter
//   Round-robin arbiter in front of a one-entry result register. The granted
//   request word has its parity computed (even, or odd when ODD=1) and,
//   if the requester asked for check mode, compared against its expected bit.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request pending
//   req_data   request words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_check  per-requester check-mode enable
//   req_exp    per-requester expected parity (used with req_check)
//   req_ready  one-hot grant, combinational
//   out_valid  result register full
//   out_ready  consumer accepts the result
//   out_id     requester index of the result
//   out_parity parity of the accepted word
//   out_error  parity check failed
//   err_count  results consumed with out_error=1, saturating at 8'hFF
//
// state | meaning
// EMPTY | no result held, slot free
// FULL  | result held; slot frees when out_ready is high

module parity_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ODD        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_check,
  input  logic [NUM_REQ-1:0]            req_exp,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    out_id,
  output logic                          out_parity,
  output logic                          out_error,
  output logic [7:0]                    err_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state;
  logic [ID_W-1:0]        last_grant;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   found;
  logic                   slot_free;
  logic                   transfer;
  logic [DATA_WIDTH-1:0]  grant_word;
  logic                   grant_parity;
  logic                   grant_error;

  assign out_valid = (state == FULL);
  assign slot_free = (state == EMPTY) || out_ready;

  // Search begins one past the last grant and wraps, so the most recently
  // served requester always has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = ID_W'(idx);
      end
    end
  end

  assign req_ready = (slot_free && !rst) ? grant : '0;
  assign transfer  = |(req_valid & req_ready);

  // Only the granted requester's word and check bits reach the datapath.
  assign grant_word   = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign grant_parity = (^grant_word) ^ (ODD != 0);
  assign grant_error  = req_check[grant_idx] && (grant_parity != req_exp[grant_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      last_grant <= ID_W'(NUM_REQ - 1);
      out_id     <= '0;
      out_parity <= 1'b0;
      out_error  <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      if (out_valid && out_ready && out_error && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      if (transfer) begin
        last_grant <= grant_idx;
        out_id     <= grant_idx;
        out_parity <= grant_parity;
        out_error  <= grant_error;
      end

      case (state)
        EMPTY: if (transfer) state <= FULL;
        FULL:  if (out_ready && !transfer) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Scoreboard bench for parity_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// An ODD=1 instance shares the stimulus so parity inversion can be observed.

module tb_parity_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_check, req_exp;
  logic [31:0] req_data;
  logic        out_ready;
  logic [3:0]  req_ready, req_ready_o;
  logic        out_valid, out_parity, out_error;
  logic        out_valid_o, out_parity_o, out_error_o;
  logic [1:0]  out_id, out_id_o;
  logic [7:0]  err_count, err_count_o;

  typedef struct packed {
    logic [1:0] id;
    logic       par;
    logic       err;
  } res_t;

  res_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  parity_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ODD(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_check(req_check), .req_exp(req_exp), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_parity(out_parity), .out_error(out_error), .err_count(err_count)
  );

  parity_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_check(req_check), .req_exp(req_exp), .req_ready(req_ready_o),
    .out_valid(out_valid_o), .out_ready(out_ready), .out_id(out_id_o),
    .out_parity(out_parity_o), .out_error(out_error_o), .err_count(err_count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance to just after the next rising edge; all driving happens here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expect a grant to requester idx this cycle and queue its result.
  task automatic grant(input int idx, input logic par, input logic err);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    #1;
    chk("req_ready grant", 32'(req_ready), 32'(oh));
    exp_q.push_back('{id: 2'(idx), par: par, err: err});
  endtask

  // Monitor: pops one expected result per consumed output.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL result unexpected: id=%0d par=%0b err=%0b", out_id, out_parity, out_error);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          if ({out_id, out_parity, out_error} !== e) begin
            n_fail++;
            $display("FAIL result: got id=%0d par=%0b err=%0b, expected id=%0d par=%0b err=%0b",
                     out_id, out_parity, out_error, e.id, e.par, e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_check = '0; req_exp = '0;
    req_data = '0; out_ready = 1'b1;
    #12;
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_id", 32'(out_id), 0);
    chk("reset out_parity", 32'(out_parity), 0);
    chk("reset err_count", 32'(err_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin with all requesters pending: 0,1,2,3,0.
    req_data = {8'h07, 8'h03, 8'h01, 8'h00};
    grant(0, 1'b0, 1'b0); cyc();
    grant(1, 1'b1, 1'b0); cyc();
    grant(2, 1'b0, 1'b0); cyc();
    grant(3, 1'b1, 1'b0); cyc();
    grant(0, 1'b0, 1'b0); cyc();
    req_valid = 4'b0000; #1;
    chk("idle req_ready", 32'(req_ready), 0);
    cyc();

    // Parity of A5 and 07 through requester 2, both polarities.
    req_valid = 4'b0100; req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    grant(2, 1'b0, 1'b0); cyc();
    chk("odd parity A5", 32'(out_parity_o), 1);
    req_data = {8'h00, 8'h07, 8'h00, 8'h00};
    grant(2, 1'b1, 1'b0); cyc();
    chk("odd parity 07", 32'(out_parity_o), 0);
    req_valid = 4'b0000; cyc();

    // Backpressure: result held, no grant, then grant on out_ready rise.
    out_ready = 1'b0;
    req_valid = 4'b0001; req_data = {8'h00, 8'h00, 8'h01, 8'h0F};
    grant(0, 1'b0, 1'b0); cyc();
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall req_ready", 32'(req_ready), 0);
      chk("stall out_valid", 32'(out_valid), 1);
      chk("stall out_id", 32'(out_id), 0);
      chk("stall out_parity", 32'(out_parity), 0);
      cyc();
    end
    out_ready = 1'b1;
    grant(1, 1'b1, 1'b0); cyc();
    grant(0, 1'b0, 1'b0); cyc();
    req_valid = 4'b0000; cyc();

    // Check-mode error on requester 1 and err_count saturation.
    req_valid = 4'b0010; req_check = 4'b0010; req_exp = 4'b0000;
    req_data = {8'h00, 8'h00, 8'h01, 8'h00};
    grant(1, 1'b1, 1'b1); cyc();
    req_valid = 4'b0000;
    chk("err_count before consume", 32'(err_count), 0);
    cyc();
    chk("err_count after consume", 32'(err_count), 1);
    req_valid = 4'b0010;
    for (int i = 0; i < 300; i++) begin
      grant(1, 1'b1, 1'b1); cyc();
    end
    req_valid = 4'b0000; req_check = 4'b0000;
    cyc(); cyc();
    chk("err_count saturated", 32'(err_count), 8'hFF);

    // Lone requester 3 granted every cycle.
    req_valid = 4'b1000; req_data = {8'hFF, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      grant(3, 1'b0, 1'b0); cyc();
    end
    req_valid = 4'b0000; cyc(); cyc();

    // Reset while holding an error result: discarded, not counted.
    out_ready = 1'b0;
    req_valid = 4'b0010; req_check = 4'b0010; req_exp = 4'b0000;
    req_data = {8'h00, 8'h00, 8'h01, 8'h00};
    #1;
    chk("pre-reset grant", 32'(req_ready), 32'(4'b0010));
    cyc();
    req_valid = 4'b0000; req_check = 4'b0000;
    #1;
    chk("pre-reset out_valid", 32'(out_valid), 1);
    chk("pre-reset out_error", 32'(out_error), 1);
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset err_count", 32'(err_count), 0);
    chk("async reset out_error", 32'(out_error), 0);
    cyc(); cyc();
    rst = 1'b0; out_ready = 1'b1;
    req_valid = 4'b1111; req_data = {8'h00, 8'h00, 8'h00, 8'h0F};
    grant(0, 1'b0, 1'b0); cyc();
    req_valid = 4'b0000;
    cyc(); cyc();
    chk("err_count after reset", 32'(err_count), 0);
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
